// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths and write-request type
package rf_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wreq_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr, wrapping
module rr_arbiter #(
  parameter int NREQ  = 3,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] winner
);

  logic found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[k] && (IDX_W'(k) >= ptr)) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        winner   = IDX_W'(k);
      end
    end
    // Nothing at or above ptr: wrap around to the lowest requesting index.
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        winner   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin write-back arbiter for the register file write port
module rf_wb_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int DATA_W = rf_pkg::DATA_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREQ-1:0]          i_req_valid,
  output logic [NREQ-1:0]          o_req_ready,
  input  logic [NREQ*ADDR_W-1:0]   i_req_addr,
  input  logic [NREQ*DATA_W-1:0]   i_req_data,
  output logic                     o_we,
  output logic [ADDR_W-1:0]        o_waddr,
  output logic [DATA_W-1:0]        o_wdata,
  output logic [2**ADDR_W-1:0]     o_pending
);

  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]   hold_v;
  logic [ADDR_W-1:0] hold_addr [NREQ];
  logic [DATA_W-1:0] hold_data [NREQ];
  logic [IDX_W-1:0]  rr_ptr;

  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  winner;
  logic              any_grant;
  logic [NREQ-1:0]   accept;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req    (hold_v),
    .ptr    (rr_ptr),
    .grant  (grant),
    .winner (winner)
  );

  // A slot being granted this cycle frees up on the same edge, so it can reload without a bubble.
  assign o_req_ready = ~hold_v | grant;
  assign accept      = i_req_valid & o_req_ready;
  assign any_grant   = |grant;

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        win_addr = hold_addr[k];
        win_data = hold_data[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_v  <= '0;
      rr_ptr  <= '0;
      o_we    <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (accept[k]) begin
          hold_v[k] <= 1'b1;
        end else if (grant[k]) begin
          hold_v[k] <= 1'b0;
        end
      end
      if (any_grant) begin
        rr_ptr  <= (winner == IDX_W'(NREQ-1)) ? '0 : winner + IDX_W'(1);
        o_waddr <= win_addr;
        o_wdata <= win_data;
      end
      // Writes to register 0 are consumed but never reach the register file.
      o_we <= any_grant && (win_addr != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NREQ; k++) begin
      if (accept[k]) begin
        hold_addr[k] <= i_req_addr[k*ADDR_W +: ADDR_W];
        hold_data[k] <= i_req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    o_pending = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (hold_v[k]) begin
        o_pending[hold_addr[k]] = 1'b1;
      end
    end
    if (o_we) begin
      o_pending[o_waddr] = 1'b1;
    end
    o_pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int NREQ  = 3;
  localparam int AW    = rf_pkg::ADDR_W;
  localparam int DW    = rf_pkg::DATA_W;
  localparam int NPEND = rf_pkg::NREG;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [NPEND-1:0]  pending;

  int    checks   = 0;
  int    failures = 0;
  wreq_t sb[$];
  wreq_t mon_e;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .NREQ   (NREQ),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .o_we        (we),
    .o_waddr     (waddr),
    .o_wdata     (wdata),
    .o_pending   (pending)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[k]         = 1'b1;
    req_addr[k*AW +: AW] = a;
    req_data[k*DW +: DW] = d;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wreq_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Every register-file write must match the next expected write, in order.
  always @(negedge clk) begin
    if (!rst && we) begin
      if (sb.size() == 0) begin
        chk("unexpected_we", 64'(we), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_addr", 64'(waddr), 64'(mon_e.addr));
        chk("wb_data", 64'(wdata), 64'(mon_e.data));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;

    set_req(0, 5'd20, 32'hA000_0000);
    set_req(1, 5'd21, 32'hA000_0001);
    set_req(2, 5'd22, 32'hA000_0002);
    tick();
    tick();
    chk("rst_ready", 64'(req_ready), 64'(3'b111));
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);

    rst = 1'b0;
    expect_wr(5'd20, 32'hA000_0000);
    expect_wr(5'd21, 32'hA000_0001);
    expect_wr(5'd22, 32'hA000_0002);
    chk("post_rst_ready", 64'(req_ready), 64'(3'b111));
    tick();
    req_valid = '0;
    chk("acc_all_pending", 64'(pending), 64'h0070_0000);
    chk("acc_all_ready", 64'(req_ready), 64'(3'b001));
    chk("acc_all_we", 64'(we), 64'd0);
    tick();
    chk("first_grant_addr", 64'(waddr), 64'd20);
    tick();
    tick();
    tick();
    chk("acc_all_drain_we", 64'(we), 64'd0);
    chk("acc_all_drain_pend", 64'(pending), 64'd0);

    set_req(0, 5'd5, 32'hDEAD_BEEF);
    expect_wr(5'd5, 32'hDEAD_BEEF);
    chk("single_pre_pend", 64'(pending), 64'd0);
    tick();
    req_valid = '0;
    chk("single_hold_pend", 64'(pending), 64'h20);
    chk("single_hold_we", 64'(we), 64'd0);
    tick();
    chk("single_we", 64'(we), 64'd1);
    chk("single_waddr", 64'(waddr), 64'd5);
    chk("single_wdata", 64'(wdata), 64'hDEAD_BEEF);
    chk("single_out_pend", 64'(pending), 64'h20);
    tick();
    chk("single_done_we", 64'(we), 64'd0);
    chk("single_done_pend", 64'(pending), 64'd0);

    set_req(1, 5'd0, 32'h0000_1234);
    tick();
    req_valid = '0;
    chk("zero_ready", 64'(req_ready), 64'(3'b111));
    chk("zero_hold_pend", 64'(pending), 64'd0);
    tick();
    chk("zero_we_a", 64'(we), 64'd0);
    chk("zero_pend_a", 64'(pending), 64'd0);
    chk("zero_ready_b", 64'(req_ready), 64'(3'b111));
    tick();
    chk("zero_we_b", 64'(we), 64'd0);

    for (int i = 0; i < 8; i++) begin
      set_req(2, AW'(8 + i), 32'hC0DE_0000 + 32'(i));
      expect_wr(AW'(8 + i), 32'hC0DE_0000 + 32'(i));
      chk("stream_ready", 64'(req_ready[2]), 64'd1);
      if (i >= 2) begin
        chk("stream_we", 64'(we), 64'd1);
        chk("stream_waddr", 64'(waddr), 64'(8 + i - 2));
      end
      tick();
    end
    req_valid = '0;
    chk("stream_we_7", 64'(we), 64'd1);
    chk("stream_waddr_7", 64'(waddr), 64'd14);
    tick();
    chk("stream_we_8", 64'(we), 64'd1);
    chk("stream_waddr_8", 64'(waddr), 64'd15);
    tick();
    chk("stream_end_we", 64'(we), 64'd0);
    chk("stream_end_pend", 64'(pending), 64'd0);

    set_req(0, 5'd1, 32'hB000_0001);
    set_req(1, 5'd2, 32'hB000_0002);
    set_req(2, 5'd3, 32'hB000_0003);
    expect_wr(5'd1, 32'hB000_0001);
    expect_wr(5'd2, 32'hB000_0002);
    expect_wr(5'd3, 32'hB000_0003);
    tick();
    req_valid = '0;
    set_req(0, 5'd4, 32'hB000_0004);
    expect_wr(5'd4, 32'hB000_0004);
    chk("cont_ready_a", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = '0;
    chk("cont_we_0", 64'(we), 64'd1);
    chk("cont_waddr_0", 64'(waddr), 64'd1);
    chk("cont_ready_b", 64'(req_ready), 64'(3'b010));
    tick();
    chk("cont_waddr_1", 64'(waddr), 64'd2);
    tick();
    chk("cont_waddr_2", 64'(waddr), 64'd3);
    tick();
    chk("cont_waddr_rot", 64'(waddr), 64'd4);
    tick();
    chk("cont_end_we", 64'(we), 64'd0);
    chk("cont_end_pend", 64'(pending), 64'd0);

    set_req(0, 5'd6, 32'hE000_0006);
    set_req(1, 5'd7, 32'hE000_0007);
    set_req(2, 5'd10, 32'hE000_000A);
    tick();
    req_valid = '0;
    chk("mid_full_pend", 64'(pending), 64'h0000_04C0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_we", 64'(we), 64'd0);
    chk("mid_rst_pend", 64'(pending), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'(3'b111));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_no_we", 64'(we), 64'd0);
    end

    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
